// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: prescaled pixel tick, column/line/pixel
// counters and a registered output stage that lags the counters by one clock.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CLK_DIV  = 1,
  parameter int   HW       = 10,
  parameter int   VW       = 10,
  parameter int   PW       = 19
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  output logic          h_sync_o,
  output logic          v_sync_o,
  output logic          pixel_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic [PW-1:0] p_count_o,
  output logic          pix_en_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // A one-bit prescaler that never leaves zero when CLK_DIV is 1.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [PW-1:0] pc_q, pc_d;

  logic          h_sync_q, v_sync_q, pixel_q;
  logic [HW-1:0] x_q;
  logic [VW-1:0] y_q;
  logic [PW-1:0] p_count_q;
  logic          pix_en_q, line_start_q, frame_start_q;

  logic pe, h_last, v_last, active, hs_region, vs_region;

  assign pe        = (div_q == DIV_LAST);
  assign h_last    = (hc_q == H_LAST);
  assign v_last    = (vc_q == V_LAST);
  assign active    = (hc_q < H_ACT) && (vc_q < V_ACT);
  assign hs_region = (hc_q >= HS_BEG) && (hc_q < HS_END);
  assign vs_region = (vc_q >= VS_BEG) && (vc_q < VS_END);

  always_comb begin
    div_d = div_q;
    hc_d  = hc_q;
    vc_d  = vc_q;
    pc_d  = pc_q;
    if (pe) begin
      div_d = '0;
      hc_d  = h_last ? '0 : hc_q + HW'(1);
      if (h_last) begin
        vc_d = v_last ? '0 : vc_q + VW'(1);
      end
      // Frame wrap wins over the increment so P_COUNT restarts at 0 on (0,0).
      if (h_last && v_last) begin
        pc_d = '0;
      end else if (active) begin
        pc_d = pc_q + PW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      pc_q          <= '0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      pixel_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      p_count_q     <= '0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (en_i) begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      pc_q          <= pc_d;
      h_sync_q      <= hs_region ? H_POL : ~H_POL;
      v_sync_q      <= vs_region ? V_POL : ~V_POL;
      pixel_q       <= active;
      x_q           <= hc_q;
      y_q           <= vc_q;
      p_count_q     <= pc_q;
      pix_en_q      <= pe;
      line_start_q  <= pe && (hc_q == '0);
      frame_start_q <= pe && (hc_q == '0) && (vc_q == '0);
    end
  end

  assign h_sync_o      = h_sync_q;
  assign v_sync_o      = v_sync_q;
  assign pixel_o       = pixel_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign p_count_o     = p_count_q;
  assign pix_en_o      = pix_en_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small raster configurations driven together and
// compared every clock against an arithmetic model of the raster position.
module tb_vga_timing_gen;

  // Config A: 15x9 raster, CLK_DIV=3, positive H sync, negative V sync.
  localparam int A_HA = 8, A_HFP = 2, A_HS = 3, A_HBP = 2;
  localparam int A_VA = 5, A_VFP = 1, A_VS = 2, A_VBP = 1;
  localparam int A_DIV = 3;
  localparam logic A_HPOL = 1'b1, A_VPOL = 1'b0;
  // Config B: 10x7 raster, CLK_DIV=1, both syncs negative.
  localparam int B_HA = 6, B_HFP = 1, B_HS = 2, B_HBP = 1;
  localparam int B_VA = 4, B_VFP = 1, B_VS = 1, B_VBP = 1;
  localparam int B_DIV = 1;
  localparam logic B_HPOL = 1'b0, B_VPOL = 1'b0;

  localparam int A_FRAME = (A_HA+A_HFP+A_HS+A_HBP) * (A_VA+A_VFP+A_VS+A_VBP) * A_DIV;
  localparam int B_FRAME = (B_HA+B_HFP+B_HS+B_HBP) * (B_VA+B_VFP+B_VS+B_VBP) * B_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic       a_hs, a_vs, a_pix, a_pe, a_ls, a_fs;
  logic [4:0] a_x;
  logic [3:0] a_y;
  logic [5:0] a_p;
  logic       b_hs, b_vs, b_pix, b_pe, b_ls, b_fs;
  logic [3:0] b_x;
  logic [2:0] b_y;
  logic [4:0] b_p;

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .H_POL(A_HPOL), .V_POL(A_VPOL), .CLK_DIV(A_DIV), .HW(5), .VW(4), .PW(6)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .h_sync_o(a_hs), .v_sync_o(a_vs), .pixel_o(a_pix),
    .x_o(a_x), .y_o(a_y), .p_count_o(a_p),
    .pix_en_o(a_pe), .line_start_o(a_ls), .frame_start_o(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .H_POL(B_HPOL), .V_POL(B_VPOL), .CLK_DIV(B_DIV), .HW(4), .VW(3), .PW(5)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .h_sync_o(b_hs), .v_sync_o(b_vs), .pixel_o(b_pix),
    .x_o(b_x), .y_o(b_y), .p_count_o(b_p),
    .pix_en_o(b_pe), .line_start_o(b_ls), .frame_start_o(b_fs)
  );

  typedef struct packed {
    logic        hs, vs, pix, pe, ls, fs;
    logic [31:0] x, y, p;
  } obs_t;

  obs_t obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {a_hs, a_vs, a_pix, a_pe, a_ls, a_fs, 32'(a_x), 32'(a_y), 32'(a_p)};
  assign obs_b = {b_hs, b_vs, b_pix, b_pe, b_ls, b_fs, 32'(b_x), 32'(b_y), 32'(b_p)};

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;   // enabled clocks since reset
  int cyc     = 0;

  // Outputs after an enabled edge describe the raster position reached after k enabled clocks.
  function automatic obs_t model(input int kk, input int ha, input int hfp, input int hsw,
                                 input int hbp, input int va, input int vfp, input int vsw,
                                 input int vbp, input logic hpol, input logic vpol, input int dv);
    obs_t o;
    int ht = ha + hfp + hsw + hbp;
    int vt = va + vfp + vsw + vbp;
    int pix = kk / dv;
    int d   = kk % dv;
    int hc  = pix % ht;
    int vc  = (pix / ht) % vt;
    o.x   = 32'(hc);
    o.y   = 32'(vc);
    o.pix = (hc < ha) && (vc < va);
    o.p   = (vc < va) ? 32'(vc * ha + ((hc < ha) ? hc : ha)) : 32'(ha * va);
    o.hs  = (hc >= ha + hfp && hc < ha + hfp + hsw) ? hpol : ~hpol;
    o.vs  = (vc >= va + vfp && vc < va + vfp + vsw) ? vpol : ~vpol;
    o.pe  = (d == dv - 1);
    o.ls  = o.pe && (hc == 0);
    o.fs  = o.pe && (hc == 0) && (vc == 0);
    return o;
  endfunction

  function automatic obs_t reset_val(input logic hpol, input logic vpol);
    obs_t o;
    o    = '0;
    o.hs = ~hpol;
    o.vs = ~vpol;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t o, input obs_t e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s t=%0t got x=%0d y=%0d p=%0d hs=%0b vs=%0b pix=%0b pe=%0b ls=%0b fs=%0b want x=%0d y=%0d p=%0d hs=%0b vs=%0b pix=%0b pe=%0b ls=%0b fs=%0b",
             tag, $time, o.x, o.y, o.p, o.hs, o.vs, o.pix, o.pe, o.ls, o.fs,
             e.x, e.y, e.p, e.hs, e.vs, e.pix, e.pe, e.ls, e.fs);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare both DUTs.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      k = 0;
      exp_a = reset_val(A_HPOL, A_VPOL);
      exp_b = reset_val(B_HPOL, B_VPOL);
    end else if (en) begin
      exp_a = model(k, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_HPOL, A_VPOL, A_DIV);
      exp_b = model(k, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_HPOL, B_VPOL, B_DIV);
      k++;
    end
    #1;
    check("a_out", obs_a, exp_a);
    check("b_out", obs_b, exp_b);
  endtask

  initial begin
    int e0;
    int a_last;
    int b_last;
    int x_saved;
    int p_saved;

    // Reset held with EN high: reset must win.
    rst_n = 1'b0;
    en    = 1'b1;
    step();
    step();
    chk_int("rst_a_hs", int'(a_hs), 0);
    chk_int("rst_b_hs", int'(b_hs), 1);

    // First running edge.
    rst_n = 1'b1;
    step();
    e0 = cyc;
    chk_int("e0_a_pix", int'(a_pix), 1);
    chk_int("e0_a_x", int'(a_x), 0);
    chk_int("e0_a_fs", int'(a_fs), 0);
    chk_int("e0_b_fs", int'(b_fs), 1);

    // Free run: strobe periods.
    a_last = -1;
    b_last = e0;
    for (int i = 0; i < 900; i++) begin
      step();
      if (a_fs) begin
        if (a_last < 0) chk_int("a_fs_first", cyc - e0, A_DIV - 1);
        else            chk_int("a_fs_period", cyc - a_last, A_FRAME);
        a_last = cyc;
      end
      if (b_fs) begin
        chk_int("b_fs_period", cyc - b_last, B_FRAME);
        b_last = cyc;
      end
    end

    // Freeze for 10 clocks.
    x_saved = int'(a_x);
    p_saved = int'(a_p);
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk_int("freeze_a_x", int'(a_x), x_saved);
    chk_int("freeze_a_p", int'(a_p), p_saved);
    en = 1'b1;
    for (int i = 0; i < 40; i++) step();

    // One-edge reset mid-frame.
    rst_n = 1'b0;
    step();
    chk_int("midrst_a_x", int'(a_x), 0);
    chk_int("midrst_a_p", int'(a_p), 0);
    rst_n = 1'b1;
    step();
    chk_int("midrst_b_fs", int'(b_fs), 1);
    chk_int("midrst_a_pix", int'(a_pix), 1);

    // Randomised enable and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator. It is the successor to the fixed 640x480 VGA controller: horizontal and vertical timing, sync polarity, pixel-clock division and counter widths are all parameters. It also adds pixel coordinates, an enable/freeze input and line/frame strobes. It sits between the system clock and the pixel datapath (framebuffer read, pattern generator) and drives the monitor sync pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- H_POL / V_POL, 0 / 0, sync active level (0 = active-low)
- CLK_DIV, 1, system clocks per pixel (≥1)
- HW / VW / PW, 10 / 10 / 19, widths of X / Y / P_COUNT
- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, synchronous, active-low
- EN  in  1  run enable; low freezes all state
- H_SYNC  out  1  horizontal sync, polarity per H_POL
- V_SYNC  out  1  vertical sync, polarity per V_POL
- PIXEL  out  1  active-video flag
- X  out  HW  current column
- Y  out  VW  current line
- P_COUNT  out  PW  linear active-pixel index, Y*H_ACTIVE+X
- PIX_EN  out  1  one-clock pixel strobe, every CLK_DIV clocks
- LINE_START  out  1  strobe at column 0 of every line
- FRAME_START  out  1  strobe at (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Prescaler `div` counts 0..CLK_DIV-1 and wraps. The internal pixel tick `pe` = (div==CLK_DIV-1). With CLK_DIV=1, `pe` is always 1.
- Column counter `hc` advances on `pe`, wrapping from H_TOTAL-1 to 0.
- Line counter `vc` advances on `pe` when hc==H_TOTAL-1, wrapping from V_TOTAL-1 to 0.
- Active region: hc<H_ACTIVE and vc<V_ACTIVE.
- H sync region: H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC.
- V sync region: V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC. V sync changes only at a line boundary.
- Pixel counter `pc`:
  - increments on `pe` in the active region;
  - clears on `pe` at hc==H_TOTAL-1 and vc==V_TOTAL-1.
- Output register stage (every clock that EN=1):
  - X←hc, Y←vc, P_COUNT←pc, PIXEL←active.
  - H_SYNC←(in H sync region ? H_POL : ~H_POL); V_SYNC likewise with V_POL.
  - PIX_EN←pe; LINE_START←pe & hc==0; FRAME_START←pe & hc==0 & vc==0.
- In blanking, X/Y still count; P_COUNT holds the next active index. P_COUNT = H_ACTIVE*V_ACTIVE after the last active pixel, until the frame wraps.
- EN=0: div, hc, vc, pc and all outputs hold their values. The strobes hold too, so the pixel datapath must qualify them with EN.
- Reset has priority over EN.

## Timing
- Reset (RST_N low at a rising edge):
  - div, hc, vc, pc = 0;
  - PIXEL=0, X=0, Y=0, P_COUNT=0, PIX_EN=0, LINE_START=0, FRAME_START=0;
  - H_SYNC=~H_POL, V_SYNC=~V_POL.
- Reset mid-frame: takes effect at that edge and restarts the frame at (0,0). No partial-line completion.
- Outputs lag the counters by exactly one clock. All outputs are mutually aligned.
- E0 is the first edge with RST_N=1 and EN=1. After E0: PIXEL=1, X=0, Y=0, P_COUNT=0. PIX_EN, LINE_START and FRAME_START are 1 only if CLK_DIV=1; otherwise they first assert after edge E0+CLK_DIV-1.
- Each pixel position is held for CLK_DIV clocks. PIX_EN pulses on the last of those clocks.
- Line period = H_TOTAL*CLK_DIV clocks. Frame period = H_TOTAL*V_TOTAL*CLK_DIV clocks.
- Defaults give 420 000 clocks per frame.
- Simultaneous events: at (H_TOTAL-1, V_TOTAL-1), hc, vc and pc all wrap on the same `pe`.

## Test plan
- Defaults, reset 2 clocks then release: after first edge PIXEL=1, X=0, Y=0, FRAME_START=1. FRAME_START recurs every 420 000 clocks. LINE_START recurs every 800 clocks.
- Defaults, horizontal sync: H_SYNC falls when X=656 and stays low 96 clocks. PIXEL is high 640 clocks per visible line. V_SYNC is low for exactly 2 lines (1 600 clocks), starting at Y=490, X=0.
- Defaults, pixel count: P_COUNT=307 199 at X=639, Y=479. It reads 307 200 through blanking and 0 after the next FRAME_START.
- CLK_DIV=2, H_POL=1, V_POL=1: frame period 840 000 clocks; PIX_EN has 50 % duty; H_SYNC high for 192 clocks; V_SYNC high for 3 200 clocks.
- EN low for 10 clocks at X=100, Y=5: all outputs frozen. Resuming continues at X=101 with no skipped or repeated P_COUNT.
- RST_N low for one edge at X=300, Y=200: outputs return to reset values. The next frame starts at (0,0) with P_COUNT=0.
